// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle control FSM for the RV32I core.
// Fetches an instruction into ir, classifies it by opcode and drives the
// one-cycle strobes for register file, PC and data memory.
// Optional build macro SEQ_INSTRET_EN adds a 32-bit retired-instruction
// counter on output instret.
module core_sequencer #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned TO_W    = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  input  logic        branch_taken,
  output logic [31:0] ir,
  output logic [2:0]  state,
  output logic        rf_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        alu_src_imm,
  output logic        trap,
  output logic [1:0]  trap_cause
`ifdef SEQ_INSTRET_EN
  ,
  output logic [31:0] instret
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_IMEM_TO = 2'b10;
  localparam logic [1:0] CAUSE_DMEM_TO = 2'b11;

  // Last cycle count before expiry; unused when TIMEOUT is 0.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [31:0]     ir_q, ir_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            trap_q, trap_d;
  logic [1:0]      cause_q, cause_d;

  logic legal;
  logic is_load, is_store, is_branch, is_jal, is_jalr, uses_imm;
  logic to_expire;

  // Classify the latched instruction; anything unmatched (X/Z included) is illegal.
  always_comb begin
    legal     = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    uses_imm  = 1'b0;
    if (ir_q[1:0] == 2'b11) begin
      case (ir_q[6:2])
        OPC_LOAD:   begin legal = 1'b1; is_load = 1'b1;   uses_imm = 1'b1; end
        OPC_OP_IMM: begin legal = 1'b1;                   uses_imm = 1'b1; end
        OPC_AUIPC:  begin legal = 1'b1;                   uses_imm = 1'b1; end
        OPC_STORE:  begin legal = 1'b1; is_store = 1'b1;  uses_imm = 1'b1; end
        OPC_OP:     begin legal = 1'b1;                                    end
        OPC_LUI:    begin legal = 1'b1;                   uses_imm = 1'b1; end
        OPC_BRANCH: begin legal = 1'b1; is_branch = 1'b1;                  end
        OPC_JALR:   begin legal = 1'b1; is_jalr = 1'b1;   uses_imm = 1'b1; end
        OPC_JAL:    begin legal = 1'b1; is_jal = 1'b1;                     end
        default:    legal = 1'b0;
      endcase
    end
  end

  // Wait-limit reached on this cycle (an ack in the same cycle still wins).
  always_comb begin
    to_expire = (TIMEOUT != 0) && (cnt_q == TO_LAST);
  end

  // State, instruction register, timeout counter and sticky trap registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      cnt_q   <= '0;
      trap_q  <= 1'b0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      trap_q  <= trap_d;
      cause_q <= cause_d;
    end
  end

  // Next-state logic, fault capture and timeout counter update.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    trap_d  = trap_q;
    cause_d = cause_q;
    cnt_d   = '0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end else if (to_expire) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = CAUSE_IMEM_TO;
        end
      end
      S_DECODE: begin
        if (legal) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      S_EXEC: begin
        if (is_load || is_store) state_d = S_MEM;
        else if (is_branch)      state_d = S_FETCH;
        else                     state_d = S_WB;
      end
      S_MEM: begin
        if (dmem_ack) begin
          state_d = is_store ? S_FETCH : S_WB;
        end else if (to_expire) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = CAUSE_DMEM_TO;
        end
      end
      S_WB:   state_d = S_FETCH;
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
    // Counter restarts on every state entry and only runs while waiting on memory.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == S_FETCH || state_q == S_MEM) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Strobe generation from the current state and decoded class.
  always_comb begin
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    rf_we       = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = 2'b00;
    alu_src_imm = 1'b0;
    case (state_q)
      S_FETCH: imem_req = 1'b1;
      S_EXEC: begin
        alu_src_imm = uses_imm;
        if (is_branch) begin
          pc_we  = 1'b1;
          pc_sel = branch_taken ? 2'b01 : 2'b00;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (dmem_ack && is_store) pc_we = 1'b1;
      end
      S_WB: begin
        rf_we = 1'b1;
        pc_we = 1'b1;
        if (is_jal)       pc_sel = 2'b01;
        else if (is_jalr) pc_sel = 2'b10;
      end
      default: ;
    endcase
  end

  assign ir         = ir_q;
  assign state      = state_q;
  assign trap       = trap_q;
  assign trap_cause = cause_q;

`ifdef SEQ_INSTRET_EN
  logic [31:0] instret_q;

  // Retired-instruction count: one per PC update, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) instret_q <= '0;
    else if (pc_we) instret_q <= instret_q + 32'd1;
  end

  assign instret = instret_q;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: a table of instruction classes with
// spec latencies, hand sequences for traps/timeouts/reset, and random
// instructions checked cycle-by-cycle against a per-instruction trace model.
module tb_core_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, branch_taken;
  logic [31:0] imem_rdata, ir;
  logic [2:0]  state;
  logic        rf_we, pc_we, alu_src_imm, trap;
  logic [1:0]  pc_sel, trap_cause;
`ifdef SEQ_INSTRET_EN
  logic [31:0] instret;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_instret = '0;

  always #5 clk = ~clk;

  core_sequencer #(.TIMEOUT(16), .TO_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .branch_taken(branch_taken), .ir(ir), .state(state),
    .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel), .alu_src_imm(alu_src_imm),
    .trap(trap), .trap_cause(trap_cause)
`ifdef SEQ_INSTRET_EN
    , .instret(instret)
`endif
  );

  typedef struct packed {
    logic [2:0] st;
    logic ia, da, bt, ireq, dreq, dwe, rf, pcw, imm, irv;
    logic [1:0] psel;
  } cyc_t;

  typedef struct {
    logic [31:0] ins;
    int          wi, wd;
    logic        bt;
    int          lat, rf;
    logic [1:0]  psel;
    logic        imm;
  } vec_t;

  cyc_t tq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [13:0] obs();
    return {state, imem_req, dmem_req, dmem_we & dmem_req, rf_we, pc_we,
            pc_sel, alu_src_imm, trap, trap_cause};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Assert reset, check reset values, release, check IDLE; returns in FETCH at posedge+1.
  task automatic do_reset();
    rst_n = 1'b0;
    imem_ack = 1'b0; dmem_ack = 1'b0; branch_taken = 1'b0; imem_rdata = '0;
    #1;
    chk("rst_vec", obs(), 14'd0);
    chk("rst_ir", ir, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_instret = '0;
    #3;
    chk("idle_vec", obs(), 14'd0);
`ifdef SEQ_INSTRET_EN
    chk("rst_instret", instret, 32'd0);
`endif
    tick();
  endtask

  // Expected per-cycle behaviour of one instruction, built from the class rules.
  task automatic gen_trace(input logic [31:0] ins, input int wi, input int wd, input logic bt);
    logic [4:0] op;
    logic       ld, st, br, imm;
    logic [1:0] ws;
    cyc_t       c;
    op  = ins[6:2];
    ld  = (op == 5'b00000);
    st  = (op == 5'b01000);
    br  = (op == 5'b11000);
    imm = op inside {5'b00100, 5'b00000, 5'b01000, 5'b11001, 5'b00101, 5'b01101};
    ws  = (op == 5'b11011) ? 2'b01 : (op == 5'b11001) ? 2'b10 : 2'b00;
    tq.delete();
    for (int i = 0; i <= wi; i++) begin
      c = '0; c.st = 3'd1; c.ireq = 1'b1; c.ia = (i == wi); tq.push_back(c);
    end
    c = '0; c.st = 3'd2; c.irv = 1'b1; tq.push_back(c);
    c = '0; c.st = 3'd3; c.irv = 1'b1; c.imm = imm; c.bt = bt;
    if (br) begin c.pcw = 1'b1; c.psel = bt ? 2'b01 : 2'b00; end
    tq.push_back(c);
    if (ld || st) begin
      for (int j = 0; j <= wd; j++) begin
        c = '0; c.st = 3'd4; c.irv = 1'b1; c.dreq = 1'b1; c.dwe = st; c.da = (j == wd);
        c.pcw = st && (j == wd);
        tq.push_back(c);
      end
    end
    if (!br && !st) begin
      c = '0; c.st = 3'd5; c.irv = 1'b1; c.rf = 1'b1; c.pcw = 1'b1; c.psel = ws;
      tq.push_back(c);
    end
  endtask

  // Drive the trace's inputs (random acks where they must be ignored) and compare every cycle.
  task automatic run_trace(input logic [31:0] ins);
    cyc_t c;
    foreach (tq[k]) begin
      c = tq[k];
      imem_ack     = (c.st == 3'd1) ? c.ia : 1'($urandom);
      dmem_ack     = (c.st == 3'd4) ? c.da : 1'($urandom);
      branch_taken = (c.st == 3'd3) ? c.bt : 1'($urandom);
      imem_rdata   = (c.st == 3'd1 && c.ia) ? ins : $urandom;
      #3;
`ifdef SEQ_INSTRET_EN
      if (k == 0) chk("instret", instret, exp_instret);
`endif
      chk("trace", obs(), {c.st, c.ireq, c.dreq, c.dwe, c.rf, c.pcw, c.psel, c.imm, 1'b0, 2'b00});
      if (c.irv) chk("ir", ir, ins);
      if (c.pcw) exp_instret++;
      tick();
    end
  endtask

  // Reactive memory model: measure latency and strobes of one instruction.
  task automatic run_table(input vec_t v, input int idx);
    int fcnt = 0, mcnt = 0, cyc = 0, rf = 0, pc = 0;
    logic [1:0] psel = 2'b00;
    logic imm = 1'b0;
    bit left = 0, done = 0;
    while (cyc < 40 && !done) begin
      imem_ack     = (state == 3'd1) && (fcnt == v.wi);
      imem_rdata   = imem_ack ? v.ins : $urandom;
      dmem_ack     = (state == 3'd4) && (mcnt == v.wd);
      branch_taken = v.bt;
      #3;
      if (state == 3'd1 && left) begin
        done = 1;
      end else begin
        if (state == 3'd1) fcnt++;
        else left = 1;
        if (state == 3'd4) mcnt++;
        if (state == 3'd3) imm = alu_src_imm;
        if (rf_we) rf++;
        if (pc_we) begin pc++; psel = pc_sel; end
        cyc++;
        tick();
      end
    end
    if (!done) chk($sformatf("tbl%0d_timeout", idx), 32'd0, 32'd1);
    chk($sformatf("tbl%0d_lat", idx), cyc, v.lat);
    chk($sformatf("tbl%0d_rf", idx), rf, v.rf);
    chk($sformatf("tbl%0d_pcwe", idx), pc, 32'd1);
    chk($sformatf("tbl%0d_pcsel", idx), psel, v.psel);
    chk($sformatf("tbl%0d_imm", idx), imm, v.imm);
    exp_instret++;
  endtask

  // TRAP must hold with all strobes low regardless of inputs.
  task automatic trap_hold(input logic [1:0] cause, input logic [31:0] ir_exp, input int n);
    for (int i = 0; i < n; i++) begin
      imem_ack = 1'($urandom); dmem_ack = 1'($urandom);
      branch_taken = 1'($urandom); imem_rdata = $urandom;
      #3;
      chk("trap_vec", obs(), {3'd6, 8'b0, 1'b1, cause});
      chk("trap_ir", ir, ir_exp);
      tick();
    end
  endtask

  task automatic illegal_case(input logic [31:0] ins);
    imem_ack = 1'b1; imem_rdata = ins; #3;
    chk("ill_fetch", state, 3'd1);
    tick();
    imem_ack = 1'b0; #3;
    chk("ill_decode", state, 3'd2);
    tick();
    trap_hold(2'b01, ins, 22);
    do_reset();
  endtask

  logic [6:0] opcs [9] = '{7'b0000011, 7'b0010011, 7'b0010111, 7'b0100011, 7'b0110011,
                           7'b0110111, 7'b1100011, 7'b1100111, 7'b1101111};
  vec_t tbl [12];

  initial begin
    tbl[0]  = '{32'h00500093, 0, 0, 1'b0, 4, 1, 2'b00, 1'b1}; // addi
    tbl[1]  = '{32'h002081B3, 0, 0, 1'b0, 4, 1, 2'b00, 1'b0}; // add
    tbl[2]  = '{32'h123450B7, 0, 0, 1'b0, 4, 1, 2'b00, 1'b1}; // lui
    tbl[3]  = '{32'h00001097, 0, 0, 1'b0, 4, 1, 2'b00, 1'b1}; // auipc
    tbl[4]  = '{32'h008000EF, 0, 0, 1'b0, 4, 1, 2'b01, 1'b0}; // jal
    tbl[5]  = '{32'h000080E7, 0, 0, 1'b0, 4, 1, 2'b10, 1'b1}; // jalr
    tbl[6]  = '{32'h0000A103, 0, 0, 1'b0, 5, 1, 2'b00, 1'b1}; // lw
    tbl[7]  = '{32'h00112223, 0, 0, 1'b0, 4, 0, 2'b00, 1'b1}; // sw
    tbl[8]  = '{32'h00112223, 0, 3, 1'b0, 7, 0, 2'b00, 1'b1}; // sw, 3 waits
    tbl[9]  = '{32'h00208463, 0, 0, 1'b1, 3, 0, 2'b01, 1'b0}; // beq taken
    tbl[10] = '{32'h00208463, 0, 0, 1'b0, 3, 0, 2'b00, 1'b0}; // beq not taken
    tbl[11] = '{32'h0000A103, 2, 1, 1'b0, 8, 1, 2'b00, 1'b1}; // lw with waits

    do_reset();

    // addi, sw with 3 data waits, beq taken/not taken
    gen_trace(32'h00500093, 0, 0, 1'b0); run_trace(32'h00500093);
    gen_trace(32'h00112223, 0, 3, 1'b0); run_trace(32'h00112223);
    gen_trace(32'h00208463, 0, 0, 1'b1); run_trace(32'h00208463);
    gen_trace(32'h00208463, 0, 0, 1'b0); run_trace(32'h00208463);

    for (int i = 0; i < 12; i++) run_table(tbl[i], i);

    // Illegal instructions
    illegal_case(32'hFFFFFFFF);
    illegal_case(32'h00000010);

    // Fetch timeout: 16 cycles without ack
    for (int i = 0; i < 16; i++) begin
      imem_ack = 1'b0; dmem_ack = 1'($urandom); #3;
      chk("ifetch_wait", state, 3'd1);
      tick();
    end
    trap_hold(2'b10, 32'd0, 5);
    do_reset();

    // Ack on the 16th fetch cycle completes normally
    gen_trace(32'h00500093, 15, 0, 1'b0); run_trace(32'h00500093);

    // Data timeout on a load
    imem_ack = 1'b1; imem_rdata = 32'h0000A103; tick();
    imem_ack = 1'b0; tick(); tick();
    for (int i = 0; i < 16; i++) begin
      dmem_ack = 1'b0; #3;
      chk("dmem_wait", {state, dmem_req}, {3'd4, 1'b1});
      tick();
    end
    trap_hold(2'b11, 32'h0000A103, 5);
    do_reset();

    // Reset during MEM of a load
    imem_ack = 1'b1; imem_rdata = 32'h0000A103; tick();
    imem_ack = 1'b0; tick(); tick();
    dmem_ack = 1'b0; #3;
    chk("mem_req_before_rst", {state, dmem_req}, {3'd4, 1'b1});
    rst_n = 1'b0; #1;
    chk("mem_rst_async", {state, dmem_req}, {3'd0, 1'b0});
    dmem_ack = 1'b1; imem_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_instret = '0;
    #3;
    chk("mem_rst_idle", state, 3'd0);
    chk("mem_rst_ir", ir, 32'd0);
`ifdef SEQ_INSTRET_EN
    chk("mem_rst_instret", instret, 32'd0);
`endif
    tick();
    imem_ack = 1'b0; #3;
    chk("mem_rst_fetch", state, 3'd1);
    tick(); #3;
    chk("mem_rst_late_ack", {state, dmem_req}, {3'd1, 1'b0});
    dmem_ack = 1'b0;
    tick();

    // Random legal instructions with random wait states
    for (int n = 0; n < 150; n++) begin
      logic [31:0] ins;
      int wi, wd;
      ins = $urandom;
      ins[6:0] = opcs[$urandom_range(0, 8)];
      wi = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 2));
      wd = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 2));
      gen_trace(ins, wi, wd, 1'($urandom));
      run_trace(ins);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
